nivel_sensor_filtro: RTL and testbench

NIVEL_SENSOR_FILTRO -- requirements
Module: nivel_sensor_filtro

---
 rtl/nivel_pkg.sv | 42 ++++
 rtl/filtro_estavel.sv | 52 +++++
 rtl/nivel_sensor_filtro.sv | 85 ++++++++
 tb/tb_nivel_sensor_filtro.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/nivel_pkg.sv
// Shared definitions for the float-switch level filter: FSM state encoding,
// the four legal sensor codes and the stability counter width.
package nivel_pkg;

    // Width of the stability counter; DEB_CYCLES must fit in it.
    localparam int CNT_W = 16;

    // Level FSM states; ERRO marks a physically impossible switch pattern.
    typedef enum logic [2:0] {
        VAZIO = 3'd0,
        BAIXO = 3'd1,
        MEDIO = 3'd2,
        ALTO  = 3'd3,
        ERRO  = 3'd4
    } estado_t;

    // Legal {a,m,b} codes: water can only fill from the bottom switch upwards.
    localparam logic [2:0] COD_VAZIO = 3'b000;
    localparam logic [2:0] COD_BAIXO = 3'b001;
    localparam logic [2:0] COD_MEDIO = 3'b011;
    localparam logic [2:0] COD_ALTO  = 3'b111;

    // True when the code is one of the four physically possible patterns.
    function automatic logic codigo_valido(input logic [2:0] codigo);
        return (codigo == COD_VAZIO) || (codigo == COD_BAIXO) ||
               (codigo == COD_MEDIO) || (codigo == COD_ALTO);
    endfunction

    // Maps a legal code to its FSM state; anything else lands in ERRO.
    function automatic estado_t estado_de(input logic [2:0] codigo);
        estado_t estado;
        case (codigo)
            COD_VAZIO: estado = VAZIO;
            COD_BAIXO: estado = BAIXO;
            COD_MEDIO: estado = MEDIO;
            COD_ALTO:  estado = ALTO;
            default:   estado = ERRO;
        endcase
        return estado;
    endfunction

endpackage

// File: rtl/filtro_estavel.sv
// Input conditioning for the three float switches: two-flop synchronizer
// followed by a stability counter. 'aceita' pulses for one cycle, in the
// cycle before the counter reaches DEB_CYCLES, so the consumer registers the
// accepted code on the very edge where the count is reached.
module filtro_estavel
    import nivel_pkg::*;
#(
    parameter int DEB_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] bruto,
    output logic [2:0] codigo,
    output logic       aceita
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] DEB_PRE = CNT_W'(DEB_CYCLES - 1);

    logic [2:0]       sinc1;
    logic [2:0]       sinc2;
    logic [2:0]       anterior;
    logic [CNT_W-1:0] contador;

    // Synchronize the raw switches, remember last cycle's code and count
    // how many consecutive cycles the code has been unchanged.
    // NOTE: all state here uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking would collapse the
    // synchronizer chain into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sinc1    <= '0;
            sinc2    <= '0;
            anterior <= '0;
            contador <= '0;
        end else begin
            sinc1    <= bruto;
            sinc2    <= sinc1;
            anterior <= sinc2;
            if (sinc2 != anterior) begin
                contador <= '0;
            end else if (contador != DEB_MAX) begin
                contador <= contador + 1'b1;
            end
        end
    end

    // The count saturates at DEB_MAX, so this fires once per stable period.
    assign aceita = (sinc2 == anterior) && (contador == DEB_PRE);
    assign codigo = sinc2;

endmodule

// File: rtl/nivel_sensor_filtro.sv
// Water level filter: debounces three float switches (high/mid/low), tracks
// the level in a small FSM and flags impossible switch combinations.
// Build option: define NIVEL_ERRO_STICKY_EN to latch ERRO until reset.
module nivel_sensor_filtro
    import nivel_pkg::*;
#(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sens_a,
    input  logic sens_m,
    input  logic sens_b,
    output logic A,
    output logic M,
    output logic B,
    output logic erro,
    output logic mudou
);

    logic [2:0] codigo;
    logic       aceita;

    estado_t    estado;
    estado_t    estado_n;
    logic [2:0] nivel_q;
    logic [2:0] nivel_n;
    logic       erro_n;
    logic       mudou_n;

    filtro_estavel #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_filtro (
        .clk    (clk),
        .reset  (reset),
        .bruto  ({sens_a, sens_m, sens_b}),
        .codigo (codigo),
        .aceita (aceita)
    );

    // Next state and next outputs; the displayed level only moves on a
    // valid code, so in ERRO it keeps showing the last valid level.
    // NOTE: every signal gets a default before the decisions below, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        estado_n = estado;
        nivel_n  = nivel_q;
        if (aceita) begin
            if (codigo_valido(codigo)) begin
`ifdef NIVEL_ERRO_STICKY_EN
                if (estado != ERRO) begin
                    estado_n = estado_de(codigo);
                    nivel_n  = codigo;
                end
`else
                estado_n = estado_de(codigo);
                nivel_n  = codigo;
`endif
            end else begin
                estado_n = ERRO;
            end
        end
        erro_n  = (estado_n == ERRO);
        mudou_n = (nivel_n != nivel_q);
    end

    // State and output registers; outputs are registered so mudou lines up
    // with the {A,M,B} update.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado  <= VAZIO;
            nivel_q <= COD_VAZIO;
            erro    <= 1'b0;
            mudou   <= 1'b0;
        end else begin
            estado  <= estado_n;
            nivel_q <= nivel_n;
            erro    <= erro_n;
            mudou   <= mudou_n;
        end
    end

    assign {A, M, B} = nivel_q;

endmodule

// File: tb/tb_nivel_sensor_filtro.sv
// Scoreboard bench for nivel_sensor_filtro with DEB_CYCLES = 4. Stimulus
// pushes the hand-derived output events (cycle, {A,M,B}, erro, mudou); the
// monitor pops one whenever the outputs change or mudou is high.
module tb_nivel_sensor_filtro;

    localparam int DEB    = 4;
    // Inputs driven just after edge c are sampled at c+1; the output updates
    // 2+DEB edges after that, and the monitor sees it in that same cycle.
    localparam int LAT    = 1 + 2 + DEB;
    localparam int ESPERA = 12;

    typedef struct {
        int         ciclo;
        logic [2:0] abm;
        logic       erro;
        logic       mudou;
    } evento_t;

    logic clk = 1'b0;
    logic reset;
    logic sens_a, sens_m, sens_b;
    logic A, M, B, erro, mudou;

    int      cyc      = 0;
    int      n_checks = 0;
    int      n_errors = 0;
    bit      mon_en   = 1'b0;
    logic [3:0] ultimo = '0;
    evento_t exp_q[$];

    nivel_sensor_filtro #(
        .DEB_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sens_a (sens_a),
        .sens_m (sens_m),
        .sens_b (sens_b),
        .A      (A),
        .M      (M),
        .B      (B),
        .erro   (erro),
        .mudou  (mudou)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        n_checks++;
        if (obtido !== esperado) begin
            n_errors++;
            $display("FAIL %s: obtido=%0h esperado=%0h (ciclo %0d)", nome, obtido, esperado, cyc);
        end
    endtask

    task automatic avanca(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic aplica(input logic [2:0] v);
        {sens_a, sens_m, sens_b} = v;
    endtask

    task automatic espera(input logic [2:0] abm, input logic e, input logic m, input int atraso);
        evento_t ev;
        ev.ciclo = cyc + atraso;
        ev.abm   = abm;
        ev.erro  = e;
        ev.mudou = m;
        exp_q.push_back(ev);
    endtask

    task automatic check_saida(input string nome, input logic [2:0] abm, input logic e);
        check(nome, {27'd0, A, M, B, erro, mudou}, {27'd0, abm, e, 1'b0});
    endtask

    // Monitor: any output change or mudou pulse must match the next event.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] atual;
            atual = {A, M, B, erro};
            if (atual != ultimo || mudou) begin
                if (exp_q.size() == 0) begin
                    check("evento_inesperado", {27'd0, atual, mudou}, {27'd0, ultimo, 1'b0});
                end else begin
                    evento_t ev;
                    ev = exp_q.pop_front();
                    check("evento_ciclo", cyc, ev.ciclo);
                    check("evento_saida", {27'd0, atual, mudou}, {27'd0, ev.abm, ev.erro, ev.mudou});
                end
            end
            ultimo = atual;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: obtido=timeout esperado=fim (ciclo %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        aplica(3'b000);
        avanca(3);
        check_saida("reset", 3'b000, 1'b0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // 000 held from reset: accepted silently, no mudou.
        avanca(ESPERA);
        check_saida("vazio_estavel", 3'b000, 1'b0);

        // 000 -> 001.
        aplica(3'b001);
        espera(3'b001, 1'b0, 1'b1, LAT);
        avanca(ESPERA);
        check_saida("baixo", 3'b001, 1'b0);

        // 001 -> 011.
        aplica(3'b011);
        espera(3'b011, 1'b0, 1'b1, LAT);
        avanca(ESPERA);
        check_saida("medio", 3'b011, 1'b0);

        // 3-cycle glitch to 111 must be ignored.
        aplica(3'b111);
        avanca(3);
        aplica(3'b011);
        avanca(ESPERA);
        check_saida("glitch", 3'b011, 1'b0);

        // Back to BAIXO, then an impossible 101.
        aplica(3'b001);
        espera(3'b001, 1'b0, 1'b1, LAT);
        avanca(ESPERA);
        aplica(3'b101);
        espera(3'b001, 1'b1, 1'b0, LAT);
        avanca(ESPERA);
        check_saida("erro", 3'b001, 1'b1);

        // Valid 011 after ERRO, then a 000 -> 111 jump.
        aplica(3'b011);
`ifndef NIVEL_ERRO_STICKY_EN
        espera(3'b011, 1'b0, 1'b1, LAT);
`endif
        avanca(ESPERA);
        aplica(3'b000);
`ifndef NIVEL_ERRO_STICKY_EN
        espera(3'b000, 1'b0, 1'b1, LAT);
`endif
        avanca(ESPERA);
        aplica(3'b111);
`ifndef NIVEL_ERRO_STICKY_EN
        espera(3'b111, 1'b0, 1'b1, LAT);
`endif
        avanca(ESPERA);
`ifdef NIVEL_ERRO_STICKY_EN
        check_saida("erro_fixo", 3'b001, 1'b1);
`else
        check_saida("salto_alto", 3'b111, 1'b0);
`endif

        // Reset 3 cycles into debouncing 011: pending code discarded, then a
        // full interval from release before 011 is accepted.
        aplica(3'b011);
        avanca(3);
        reset = 1'b1;
        espera(3'b000, 1'b0, 1'b0, 1);
        avanca(2);
        check_saida("reset_meio", 3'b000, 1'b0);
        reset = 1'b0;
        espera(3'b011, 1'b0, 1'b1, LAT);
        avanca(ESPERA);
        check_saida("pos_reset", 3'b011, 1'b0);

        check("fila_vazia", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
